// File: rtl/biquad_cfg_pkg.sv
// Shared types and helpers for the biquad cascade configuration sequencer.
// Pure definitions: no latency, no flow control.
package biquad_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_DRIVE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [31:0] Q31_ONE = 32'h7FFF_FFFF;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;

  localparam int N_COEFS = 5;

  // Coefficient k occupies bits 32k+31:32k.
  typedef logic [N_COEFS-1:0][31:0] coef_set_t;

  // Pass-through filter: b0 = 1.0, everything else 0.
  function automatic coef_set_t identity_coefs();
    coef_set_t c;
    c     = '0;
    c[B0] = Q31_ONE;
    return c;
  endfunction

  function automatic logic [511:0] pack_config(input coef_set_t c);
    logic [511:0] w;
    w        = '0;
    w[159:0] = c;
    return w;
  endfunction

endpackage

// File: rtl/biquad_coef_bank.sv
// Staging and shadow coefficient banks; writes and snapshot land at the clock edge, read is combinational.
// No backpressure: every valid write is accepted, snapshot copies the pre-edge staging bank.
module biquad_coef_bank
#(
  parameter int N_STAGES = 4
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [2:0]   wr_stage,
  input  logic [2:0]   wr_sel,
  input  logic [31:0]  wr_data,
  input  logic         snap,
  input  logic [2:0]   rd_stage,
  output logic [159:0] rd_coefs
);
  import biquad_cfg_pkg::*;

  coef_set_t staging [N_STAGES];
  coef_set_t shadow  [N_STAGES];

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int s = 0; s < N_STAGES; s++) begin
        staging[s] <= identity_coefs();
        shadow[s]  <= identity_coefs();
      end
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        if (wr_en && (wr_stage == 3'(s))) begin
          staging[s][wr_sel] <= wr_data;
        end
        if (snap) begin
          shadow[s] <= staging[s];
        end
      end
    end
  end

  // Loop compare keeps the index width independent of N_STAGES.
  always_comb begin
    rd_coefs = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (rd_stage == 3'(s)) begin
        rd_coefs = shadow[s];
      end
    end
  end

endmodule

// File: rtl/biquad_cascade_config_sequencer.sv
// Snapshots staged biquad coefficients on commit and presents them stage by stage on a shared config bus.
// Latency: commit -> busy 1 cycle, -> stage-0 address 2 cycles; no backpressure, commits while busy coalesce into one rerun.
module biquad_cascade_config_sequencer
#(
  parameter int          N_STAGES      = 4,
  parameter logic [31:0] BASE_ADDR     = 32'd1000,
  parameter logic [31:0] IDLE_ADDR     = 32'd0,
  parameter int          HOLD_CYCLES   = 2,
  parameter int          GAP_CYCLES    = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_stage,
  input  logic [2:0]   cfg_sel,
  input  logic [31:0]  cfg_wdata,
  input  logic         commit,
  output logic         busy,
  output logic         done,
  output logic         wr_err,
  output logic [31:0]  config_addr,
  output logic [511:0] config_data
);
  import biquad_cfg_pkg::*;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t          state, state_nxt;
  logic [2:0]      stage, stage_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic            pending, pending_nxt;
  logic            snap;
  logic            wr_valid;
  logic [159:0]    rd_coefs;

  logic            busy_nxt, done_nxt, wr_err_nxt;
  logic [31:0]     addr_nxt;
  logic [511:0]    data_nxt;

  assign wr_valid = cfg_we && (int'(cfg_stage) < N_STAGES) && (cfg_sel <= A2);

  biquad_coef_bank #(
    .N_STAGES (N_STAGES)
  ) u_bank (
    .aclk     (aclk),
    .reset    (reset),
    .wr_en    (wr_valid),
    .wr_stage (cfg_stage),
    .wr_sel   (cfg_sel),
    .wr_data  (cfg_wdata),
    .snap     (snap),
    .rd_stage (stage),
    .rd_coefs (rd_coefs)
  );

  always_comb begin
    state_nxt   = state;
    stage_nxt   = stage;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    pending_nxt = pending;
    snap        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (commit || pending) begin
          state_nxt   = ST_SNAP;
          pending_nxt = 1'b0;
        end
      end
      ST_SNAP: begin
        snap      = 1'b1;
        stage_nxt = 3'd0;
        hold_nxt  = '0;
        state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          if (int'(stage) < N_STAGES - 1) begin
            stage_nxt = stage + 3'd1;
            hold_nxt  = '0;
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      ST_DONE: begin
        if (pending) begin
          state_nxt   = ST_SNAP;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Any commit outside IDLE, including the DONE cycle, queues exactly one rerun.
    if (commit && (state != ST_IDLE)) begin
      pending_nxt = 1'b1;
    end

    busy_nxt   = (state == ST_SNAP) || (state == ST_DRIVE) || (state == ST_GAP);
    done_nxt   = (state == ST_DONE);
    wr_err_nxt = wr_err || (cfg_we && !wr_valid);
    addr_nxt   = IDLE_ADDR;
    data_nxt   = '0;
    if (state == ST_DRIVE) begin
      addr_nxt = BASE_ADDR + 32'(stage);
      data_nxt = pack_config(rd_coefs);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      stage       <= 3'd0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      pending     <= INIT_ON_RESET;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
      config_addr <= IDLE_ADDR;
      config_data <= '0;
    end else begin
      state       <= state_nxt;
      stage       <= stage_nxt;
      hold_cnt    <= hold_nxt;
      gap_cnt     <= gap_nxt;
      pending     <= pending_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      wr_err      <= wr_err_nxt;
      config_addr <= addr_nxt;
      config_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_biquad_cascade_config_sequencer.sv
// Directed bench with a timeline model of the sequencer checked every cycle, plus literal spot checks.
module tb_biquad_cascade_config_sequencer;

  localparam int N       = 4;
  localparam int HOLD    = 2;
  localparam int GAP     = 4;
  localparam int BASE    = 1000;
  localparam int SLOT    = HOLD + GAP;
  localparam int RUN_LEN = 1 + N * SLOT;

  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_stage = 3'd0;
  logic [2:0]   cfg_sel = 3'd0;
  logic [31:0]  cfg_wdata = 32'd0;
  logic         commit = 1'b0;
  logic         busy, done, wr_err;
  logic [31:0]  config_addr;
  logic [511:0] config_data;

  int total = 0;
  int bad   = 0;

  biquad_cascade_config_sequencer #(
    .N_STAGES      (N),
    .BASE_ADDR     (32'd1000),
    .IDLE_ADDR     (32'd0),
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_stage   (cfg_stage),
    .cfg_sel     (cfg_sel),
    .cfg_wdata   (cfg_wdata),
    .commit      (commit),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err),
    .config_addr (config_addr),
    .config_data (config_data)
  );

  always #5 aclk = ~aclk;

  // Model: a run is a timeline of RUN_LEN+1 cycles counted from the edge that starts it.
  logic [31:0]  m_stg [N][5];
  logic [31:0]  m_shd [N][5];
  int           m_start = -1;
  bit           m_pend  = 1'b0;
  bit           m_err   = 1'b0;
  int           cyc     = 0;
  bit           e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0]  e_addr = 32'd0;
  logic [511:0] e_data = '0;

  function automatic logic [511:0] model_word(input int s);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 5; k++) w[32*k +: 32] = m_shd[s][k];
    return w;
  endfunction

  always @(posedge aclk) begin
    int t;
    cyc++;
    t = (m_start < 0) ? -1 : cyc - m_start;
    e_busy = (t >= 1) && (t <= RUN_LEN);
    e_done = (t == RUN_LEN + 1);
    e_addr = 32'd0;
    e_data = '0;
    if (t >= 2 && (t - 2) < N * SLOT && ((t - 2) % SLOT) < HOLD) begin
      e_addr = BASE + (t - 2) / SLOT;
      e_data = model_word((t - 2) / SLOT);
    end
    if (reset) begin
      e_busy = 1'b0; e_done = 1'b0; e_addr = 32'd0; e_data = '0;
      m_err = 1'b0; m_start = -1; m_pend = 1'b1;
      for (int s = 0; s < N; s++)
        for (int k = 0; k < 5; k++) begin
          m_stg[s][k] = (k == 0) ? 32'h7FFF_FFFF : 32'd0;
          m_shd[s][k] = m_stg[s][k];
        end
    end else begin
      if (t == 1)
        for (int s = 0; s < N; s++)
          for (int k = 0; k < 5; k++) m_shd[s][k] = m_stg[s][k];
      if (cfg_we) begin
        if (int'(cfg_stage) < N && cfg_sel < 3'd5) m_stg[cfg_stage][cfg_sel] = cfg_wdata;
        else m_err = 1'b1;
      end
      if (m_start < 0) begin
        if (commit || m_pend) begin m_start = cyc; m_pend = 1'b0; end
      end else if (t == RUN_LEN + 1) begin
        if (m_pend) m_start = cyc;
        else m_start = -1;
        m_pend = commit;
      end else if (commit) begin
        m_pend = 1'b1;
      end
    end
    e_err = m_err;
  end

  always @(negedge aclk) begin
    total++;
    if ({busy, done, wr_err, config_addr, config_data} !== {e_busy, e_done, e_err, e_addr, e_data}) begin
      bad++;
      $display("FAIL model cyc=%0d busy=%b/%b done=%b/%b err=%b/%b addr=%0d/%0d data=%h/%h",
               cyc, busy, e_busy, done, e_done, wr_err, e_err, config_addr, e_addr,
               config_data[159:0], e_data[159:0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget, input string nm);
    int n = 0;
    while (config_addr !== a && n < budget) begin tick(1); n++; end
    check(nm, config_addr, a);
  endtask

  task automatic wait_sig_low(input int budget, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(1); n++; end
    check(nm, busy, 1'b0);
  endtask

  initial begin
    int bcnt, dcnt, act;
    logic [31:0] seen [$];
    logic [31:0] prev, w1, w3;

    // Reset release: identity sequence runs by itself.
    tick(3);
    check("rst_addr", config_addr, 32'd0);
    check("rst_err", wr_err, 1'b0);
    reset = 1'b0;
    tick(1); check("rel_busy0", busy, 1'b0);
    tick(1); check("rel_busy1", busy, 1'b1); check("rel_addr0", config_addr, 32'd0);
    tick(1); check("rel_addr1000", config_addr, 32'd1000);
    check("rel_w0", config_data[31:0], 32'h7FFF_FFFF);
    check("rel_rest", config_data[511:32], '0);
    bcnt = 2; dcnt = 0; prev = 32'd1000;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      bcnt += int'(busy); dcnt += int'(done);
      if (config_addr != 0 && config_addr != prev) seen.push_back(config_addr);
      if (config_addr != 0) prev = config_addr;
    end
    check("init_busy_len", bcnt, RUN_LEN);
    check("init_done_cnt", dcnt, 1);
    check("init_order", (seen.size() == 3) ? {seen[0], seen[1], seen[2]} : 96'd0,
          {32'd1001, 32'd1002, 32'd1003});

    // Write plus commit in the same cycle is included in the snapshot.
    cfg_we = 1'b1; cfg_stage = 3'd2; cfg_sel = 3'd3; cfg_wdata = 32'h4000_0000; commit = 1'b1;
    tick(1);
    cfg_we = 1'b0; commit = 1'b0;
    wait_addr(32'd1002, 40, "wc_addr1002");
    check("wc_a1", config_data[127:96], 32'h4000_0000);
    check("wc_b0", config_data[31:0], 32'h7FFF_FFFF);
    wait_addr(32'd1003, 20, "wc_addr1003");
    check("wc_s3_a1", config_data[127:96], 32'd0);
    wait_sig_low(40, "wc_idle");
    tick(2);

    // Coalesced commits and a mid-sequence write.
    commit = 1'b1; tick(4); commit = 1'b0;
    cfg_we = 1'b1; cfg_stage = 3'd1; cfg_sel = 3'd1; cfg_wdata = 32'h1234_5678;
    tick(1); cfg_we = 1'b0;
    wait_addr(32'd1001, 20, "co_addr1001_a");
    check("co_first_b1", config_data[63:32], 32'd0);
    act = 0;
    while (done !== 1'b1 && act < 40) begin tick(1); act++; end
    check("co_first_done", done, 1'b1);
    dcnt = 0; w1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      dcnt += int'(done);
      if (config_addr == 32'd1001) w1 = config_data[63:32];
    end
    check("co_reruns", dcnt, 1);
    check("co_second_b1", w1, 32'h1234_5678);

    // Invalid writes are dropped and flagged.
    cfg_we = 1'b1; cfg_stage = 3'd5; cfg_sel = 3'd0; cfg_wdata = 32'hDEAD_BEEF;
    tick(1);
    cfg_stage = 3'd0; cfg_sel = 3'd6;
    tick(1); cfg_we = 1'b0;
    tick(1); check("err_set", wr_err, 1'b1);
    commit = 1'b1; tick(1); commit = 1'b0;
    wait_addr(32'd1000, 20, "err_addr1000");
    check("err_s0_b0", config_data[31:0], 32'h7FFF_FFFF);
    wait_addr(32'd1001, 20, "err_addr1001");
    check("err_s1_b1", config_data[63:32], 32'h1234_5678);
    wait_sig_low(40, "err_idle");
    check("err_sticky", wr_err, 1'b1);
    tick(2);

    // Reset in the middle of a sequence.
    commit = 1'b1; tick(1); commit = 1'b0;
    wait_addr(32'd1001, 20, "mr_addr1001");
    reset = 1'b1;
    tick(1);
    check("mr_addr", config_addr, 32'd0);
    check("mr_busy", busy, 1'b0);
    check("mr_err", wr_err, 1'b0);
    reset = 1'b0;
    bcnt = 0; dcnt = 0; w1 = 32'hFFFF_FFFF; w3 = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      bcnt += int'(busy); dcnt += int'(done);
      if (config_addr == 32'd1001) w1 = config_data[63:32];
      if (config_addr == 32'd1002) w3 = config_data[127:96];
    end
    check("mr_busy_len", bcnt, RUN_LEN);
    check("mr_done_cnt", dcnt, 1);
    check("mr_s1_b1", w1, 32'd0);
    check("mr_s2_a1", w3, 32'd0);

    // Quiet bus with no commits.
    act = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (config_addr != 32'd0 || busy || done) act++;
    end
    check("quiet", act, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
